// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, load-use stall, branch flush, memory-wait FSM
//
// Ports:
//   clk, reset            single clock; synchronous active-low reset
//   rs1_d, rs2_d          Decode source registers
//   rs1_e, rs2_e, rd_e    Execute source/destination registers
//   result_src_e          Execute result select (2'b01 marks a load)
//   rd_m, reg_write_m     Memory-stage destination and write enable
//   rd_w, reg_write_w     Writeback destination and write enable
//   pc_src_e              taken branch/jump resolved in Execute
//   mem_req_m, mem_ready_m  data-memory access valid / completing this cycle
//   stall_f/d/e/m         hold PC, IF-ID, ID-EX, EX-MEM registers
//   flush_d/e/w           bubble IF-ID, ID-EX, MEM-WB registers
//   forward_a_e/b_e       ALU operand select: 00 regfile, 10 ALUResultM, 01 ResultW
//   stall_cnt, flush_cnt  saturating performance counters
//   mem_err               sticky memory-timeout flag
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_W          = 32,
    parameter int WAIT_MAX       = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [1:0]                result_src_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_w,
    input  logic                      pc_src_e,
    input  logic                      mem_req_m,
    input  logic                      mem_ready_m,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_w,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    output logic                      mem_err
);

    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam int         WAIT_W     = $clog2(WAIT_MAX + 1);
    // waitCnt holds the count of MEM_WAIT cycles already completed, so the
    // timeout fires in the WAIT_MAX-th MEM_WAIT cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } stateType;

    stateType              state;
    stateType              effState;
    logic [WAIT_W-1:0]     waitCnt;
    logic                  loadUse;
    logic                  memWait;
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    // Operand forwarding; Memory-stage match wins, x0 never forwards.
    always_comb begin
        forward_a_e = 2'b00;
        if (reg_write_m && rd_m == rs1_e && rs1_e != X0) begin
            forward_a_e = 2'b10;
        end else if (reg_write_w && rd_w == rs1_e && rs1_e != X0) begin
            forward_a_e = 2'b01;
        end

        forward_b_e = 2'b00;
        if (reg_write_m && rd_m == rs2_e && rs2_e != X0) begin
            forward_b_e = 2'b10;
        end else if (reg_write_w && rd_w == rs2_e && rs2_e != X0) begin
            forward_b_e = 2'b01;
        end
    end

    assign loadUse = (result_src_e == RESULT_MEM) && (rd_e != X0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign memWait = mem_req_m && !mem_ready_m;

    // While reset is held the outputs decode as if in RUN, whatever the
    // registered state still says.
    assign effState = reset ? state : RUN;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        case (effState)
            RUN: begin
                if (memWait) begin
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                end else if (pc_src_e) begin
                    // Branch redirect beats a load-use stall in the same cycle.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (loadUse) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The completing cycle releases the pipeline; branch and
                // load-use are evaluated once back in RUN.
                if (!mem_ready_m) begin
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                end
            end
            default: begin
                {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            waitCnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_m) begin
                        state <= RUN;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                        if (waitCnt >= WAIT_LAST) begin
                            state   <= ERROR;
                            mem_err <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (stall_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            // flush_d is only ever raised by a taken branch/jump.
            if (flush_d && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]    result_src_e;
    logic          reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0]    forward_a_e, forward_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_err;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_W(CW), .WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e(result_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Expected output word: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,fwdA[1:0],fwdB[1:0]}
    localparam logic [10:0] NONE    = 11'b0000000_00_00;
    localparam logic [10:0] FREEZE  = 11'b1111001_00_00;
    localparam logic [10:0] LOADUSE = 11'b1100010_00_00;
    localparam logic [10:0] BRANCH  = 11'b0000110_00_00;
    localparam logic [10:0] FA_M    = 11'b0000000_10_00;
    localparam logic [10:0] FA_W    = 11'b0000000_01_00;
    localparam logic [10:0] FB_M    = 11'b0000000_00_10;
    localparam logic [10:0] FB_W    = 11'b0000000_00_01;

    typedef struct {
        string         name;
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0]    res;
        logic [AW-1:0] rdm;
        logic          rwm;
        logic [AW-1:0] rdw;
        logic          rww;
        logic          pc, req, rdy;
        logic [10:0]   exp;
    } vecType;

    vecType      vecs[$];
    logic [10:0] expQ[$];
    string       nameQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;

    function automatic logic [10:0] obsOut();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                forward_a_e, forward_b_e};
    endfunction

    task automatic addVec(input string n, input int r1d, input int r2d, input int r1e,
                          input int r2e, input int rde, input int res, input int rdm,
                          input int rwm, input int rdw, input int rww, input int pc,
                          input int req, input int rdy, input logic [10:0] exp);
        vecType v;
        v.name = n;
        v.rs1d = AW'(r1d); v.rs2d = AW'(r2d); v.rs1e = AW'(r1e); v.rs2e = AW'(r2e);
        v.rde = AW'(rde); v.res = 2'(res); v.rdm = AW'(rdm); v.rwm = rwm[0];
        v.rdw = AW'(rdw); v.rww = rww[0]; v.pc = pc[0]; v.req = req[0]; v.rdy = rdy[0];
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic clearIn();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        result_src_e = 2'b00; reg_write_m = 1'b0; reg_write_w = 1'b0;
        pc_src_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string n, input int unsigned act, input int unsigned exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Scoreboard: expectation queued when stimulus is set, compared when
    // outputs are sampled mid-cycle.
    task automatic expectOut(input string n, input logic [10:0] exp);
        logic [10:0] e;
        string       en;
        logic [10:0] got;
        expQ.push_back(exp);
        nameQ.push_back(n);
        @(negedge clk);
        got = obsOut();
        e   = expQ.pop_front();
        en  = nameQ.pop_front();
        testsRun++;
        if (got !== e) begin
            testsFailed++;
            $display("FAIL %s: got %b expected %b", en, got, e);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearIn();
        step();
        reset = 1'b1;
    endtask

    task automatic setLoadUse();
        rd_e = 5; result_src_e = 2'b01; rs1_d = 5;
    endtask

    initial begin
        //      name          r1d r2d r1e r2e rde res rdm rwm rdw rww pc req rdy exp
        addVec("idle",          0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, NONE);
        addVec("lu_rs1",        5,  0,  0,  0,  5,  1,  0,  0,  0,  0, 0, 0, 0, LOADUSE);
        addVec("lu_rs2",        0,  5,  0,  0,  5,  1,  0,  0,  0,  0, 0, 0, 0, LOADUSE);
        addVec("lu_x0",         0,  0,  0,  0,  0,  1,  0,  0,  0,  0, 0, 0, 0, NONE);
        addVec("lu_not_load",   5,  0,  0,  0,  5,  0,  0,  0,  0,  0, 0, 0, 0, NONE);
        addVec("lu_no_match",   6,  7,  0,  0,  5,  1,  0,  0,  0,  0, 0, 0, 0, NONE);
        addVec("fwd_double",    0,  0,  7,  0,  0,  0,  7,  1,  7,  1, 0, 0, 0, FA_M);
        addVec("fwd_x0",        0,  0,  0,  0,  0,  0,  0,  1,  0,  1, 0, 0, 0, NONE);
        addVec("fwd_a_w",       0,  0,  3,  0,  0,  0,  0,  0,  3,  1, 0, 0, 0, FA_W);
        addVec("fwd_b_m",       0,  0,  0,  4,  0,  0,  4,  1,  0,  0, 0, 0, 0, FB_M);
        addVec("fwd_b_m_off",   0,  0,  0,  4,  0,  0,  4,  0,  4,  1, 0, 0, 0, FB_W);
        addVec("fwd_both",      0,  0,  9,  9,  0,  0,  9,  1,  2,  1, 0, 0, 0, FA_M | FB_M);
        addVec("branch",        0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, BRANCH);
        addVec("branch_lu",     5,  0,  0,  0,  5,  1,  0,  0,  0,  0, 1, 0, 0, BRANCH);
        addVec("mem_hit",       0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1, 1, NONE);

        // Reset behaviour: registered state clear, outputs decode as RUN.
        reset = 1'b0;
        clearIn();
        step();
        step();
        @(negedge clk);
        checkVal("rst_stall_cnt", stall_cnt, 0);
        checkVal("rst_flush_cnt", flush_cnt, 0);
        checkVal("rst_mem_err", mem_err, 0);
        pc_src_e = 1'b1;
        expectOut("rst_run_rules", BRANCH);
        step();
        @(negedge clk);
        checkVal("rst_no_count", flush_cnt, 0);
        step();
        reset = 1'b1;
        clearIn();

        // Table of single-cycle vectors in RUN.
        for (int i = 0; i < vecs.size(); i++) begin
            rs1_d = vecs[i].rs1d; rs2_d = vecs[i].rs2d; rs1_e = vecs[i].rs1e;
            rs2_e = vecs[i].rs2e; rd_e = vecs[i].rde; result_src_e = vecs[i].res;
            rd_m = vecs[i].rdm; reg_write_m = vecs[i].rwm; rd_w = vecs[i].rdw;
            reg_write_w = vecs[i].rww; pc_src_e = vecs[i].pc;
            mem_req_m = vecs[i].req; mem_ready_m = vecs[i].rdy;
            expectOut(vecs[i].name, vecs[i].exp);
            step();
        end

        // Load-use: one bubble, counter +1.
        doReset();
        setLoadUse();
        expectOut("lu_seq_stall", LOADUSE);
        step();
        result_src_e = 2'b00;
        expectOut("lu_seq_release", NONE);
        checkVal("lu_seq_stall_cnt", stall_cnt, 1);
        step();

        // Branch plus load-use: branch wins, flush_cnt +1, no stall counted.
        doReset();
        setLoadUse();
        pc_src_e = 1'b1;
        expectOut("br_lu_seq", BRANCH);
        step();
        clearIn();
        @(negedge clk);
        checkVal("br_lu_flush_cnt", flush_cnt, 1);
        checkVal("br_lu_stall_cnt", stall_cnt, 0);
        step();

        // Memory wait of three cycles, then completion.
        doReset();
        mem_req_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expectOut($sformatf("mw_freeze_%0d", i), FREEZE);
            step();
        end
        mem_ready_m = 1'b1;
        pc_src_e = 1'b1;
        expectOut("mw_ready_release", NONE);
        step();
        mem_req_m = 1'b0;
        mem_ready_m = 1'b0;
        expectOut("mw_back_in_run", BRANCH);
        checkVal("mw_stall_cnt", stall_cnt, 3);
        checkVal("mw_no_err", mem_err, 0);
        step();
        clearIn();

        // Timeout into ERROR after four MEM_WAIT cycles.
        doReset();
        mem_req_m = 1'b1;
        for (int i = 0; i < 4; i++) step();
        expectOut("to_last_wait", FREEZE);
        checkVal("to_err_not_yet", mem_err, 0);
        step();
        @(negedge clk);
        checkVal("to_err_set", mem_err, 1);
        mem_ready_m = 1'b1;
        mem_req_m = 1'b0;
        step();
        step();
        expectOut("to_error_frozen", FREEZE);
        checkVal("to_err_sticky", mem_err, 1);
        reset = 1'b0;
        clearIn();
        step();
        reset = 1'b1;
        expectOut("to_reset_run", NONE);
        checkVal("to_err_cleared", mem_err, 0);
        pc_src_e = 1'b1;
        expectOut("to_reset_branch", BRANCH);
        step();
        clearIn();

        // Saturation of the 4-bit stall counter.
        doReset();
        setLoadUse();
        for (int i = 0; i < 20; i++) step();
        clearIn();
        @(negedge clk);
        checkVal("sat_stall_cnt", stall_cnt, 15);
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
